// File: rtl/l1d_dat_ram_arb_pkg.sv
// l1d_dat_ram_arb_pkg: shared types and constants for the L1D data-RAM arbiter
package l1d_dat_ram_arb_pkg;
  localparam int L1D_DAT_RAM_ADDR_WIDTH = 9;
  localparam int L1D_DAT_RAM_RD_LAT = 2;
  localparam int L1D_DAT_RAM_ID_MAX_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, LF_BURST, EV_BURST} l1d_dat_arb_state_e;
  typedef enum logic {SRC_EV, SRC_LD} l1d_dat_rsp_src_e;
  typedef struct packed {
    logic vld;
    l1d_dat_rsp_src_e src;
    logic [L1D_DAT_RAM_ID_MAX_WIDTH-1:0] id;
  } l1d_dat_rsp_ent_t;
endpackage

// File: rtl/l1d_dat_ram_rsp_pipe.sv
// l1d_dat_ram_rsp_pipe: fixed-latency read-return tracker and response demux
module l1d_dat_ram_rsp_pipe
  import l1d_dat_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 4,
  parameter int RD_LAT = L1D_DAT_RAM_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_vld,
  input  l1d_dat_rsp_src_e      rd_src,
  input  logic [ID_WIDTH-1:0]   rd_id,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ev_rsp_vld,
  output logic [ID_WIDTH-1:0]   ev_rsp_id,
  output logic [DATA_WIDTH-1:0] ev_rsp_data,
  output logic                  ld_rsp_vld,
  output logic [ID_WIDTH-1:0]   ld_rsp_id,
  output logic [DATA_WIDTH-1:0] ld_rsp_data
);
  l1d_dat_rsp_ent_t pipe [RD_LAT];
  l1d_dat_rsp_ent_t tail;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: rd_vld, src: rd_src, id: L1D_DAT_RAM_ID_MAX_WIDTH'(rd_id)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign tail = pipe[RD_LAT-1];
  assign ev_rsp_vld = tail.vld && tail.src == SRC_EV;
  assign ld_rsp_vld = tail.vld && tail.src == SRC_LD;
  assign ev_rsp_id = ID_WIDTH'(tail.id);
  assign ld_rsp_id = ID_WIDTH'(tail.id);
  assign ev_rsp_data = ram_rdata;
  assign ld_rsp_data = ram_rdata;
endmodule

// File: rtl/l1d_dat_ram_arb.sv
// l1d_dat_ram_arb: single-port data-RAM arbiter for linefill, evict and load-hit traffic
module l1d_dat_ram_arb
  import l1d_dat_ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = L1D_DAT_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 4,
  parameter int RD_LAT = L1D_DAT_RAM_RD_LAT,
  parameter int STARVE_THR = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lf_req_vld,
  output logic                      lf_req_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] lf_req_addr,
  input  logic [DATA_WIDTH-1:0]     lf_req_wdata,
  input  logic                      lf_req_last,
  input  logic                      ev_req_vld,
  output logic                      ev_req_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] ev_req_addr,
  input  logic [ID_WIDTH-1:0]       ev_req_id,
  input  logic                      ev_req_last,
  input  logic                      ld_req_vld,
  output logic                      ld_req_rdy,
  input  logic [RAM_ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [ID_WIDTH-1:0]       ld_req_id,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      ev_rsp_vld,
  output logic [ID_WIDTH-1:0]       ev_rsp_id,
  output logic [DATA_WIDTH-1:0]     ev_rsp_data,
  output logic                      ld_rsp_vld,
  output logic [ID_WIDTH-1:0]       ld_rsp_id,
  output logic [DATA_WIDTH-1:0]     ld_rsp_data
);
  localparam int CW = $clog2(STARVE_THR + 1);
  l1d_dat_arb_state_e state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic ld_top, gnt_lf, gnt_ev, gnt_ld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // in a burst state only the owner can be granted, so any granted last beat ends it
  always_comb begin
    state_d = state_q == IDLE ? (gnt_lf && !lf_req_last ? LF_BURST :
                                 gnt_ev && !ev_req_last ? EV_BURST : IDLE) :
              (gnt_lf && lf_req_last) || (gnt_ev && ev_req_last) ? IDLE : state_q;
  end
  // grants are gated by rst_n so no requester sees rdy while reset is held
  always_comb begin
    ld_top = starve_cnt >= CW'(STARVE_THR) && ld_req_vld;
    gnt_lf = rst_n && lf_req_vld && (state_q == LF_BURST || (state_q == IDLE && !ld_top));
    gnt_ev = rst_n && ev_req_vld && (state_q == EV_BURST || (state_q == IDLE && !ld_top && !lf_req_vld));
    gnt_ld = rst_n && ld_req_vld && state_q == IDLE && (ld_top || (!lf_req_vld && !ev_req_vld));
    lf_req_rdy = gnt_lf;
    ev_req_rdy = gnt_ev;
    ld_req_rdy = gnt_ld;
    ram_en = gnt_lf || gnt_ev || gnt_ld;
    ram_we = gnt_lf;
    ram_addr = gnt_lf ? lf_req_addr : gnt_ev ? ev_req_addr : ld_req_addr;
    ram_wdata = lf_req_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else if (gnt_ld || !ld_req_vld) starve_cnt <= '0;
    else if (starve_cnt < CW'(STARVE_THR)) starve_cnt <= starve_cnt + 1'b1;
  end
  l1d_dat_ram_rsp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH(ID_WIDTH),
    .RD_LAT(RD_LAT)
  ) u_rsp_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .rd_vld(gnt_ev || gnt_ld),
    .rd_src(gnt_ld ? SRC_LD : SRC_EV),
    .rd_id(gnt_ld ? ld_req_id : ev_req_id),
    .ram_rdata(ram_rdata),
    .ev_rsp_vld(ev_rsp_vld),
    .ev_rsp_id(ev_rsp_id),
    .ev_rsp_data(ev_rsp_data),
    .ld_rsp_vld(ld_rsp_vld),
    .ld_rsp_id(ld_rsp_id),
    .ld_rsp_data(ld_rsp_data)
  );
endmodule

// File: tb/tb_l1d_dat_ram_arb.sv
// tb_l1d_dat_ram_arb: randomized traffic against a priority/ownership reference model
module tb_l1d_dat_ram_arb;
  localparam int AW = 9, DW = 128, IW = 4, RL = 2, THR = 8, NCYC = 3000;
  logic clk = 0, rst_n = 0;
  logic lf_req_vld = 0, lf_req_last = 0, ev_req_vld = 0, ev_req_last = 0, ld_req_vld = 0;
  logic lf_req_rdy, ev_req_rdy, ld_req_rdy, ram_en, ram_we, ev_rsp_vld, ld_rsp_vld;
  logic [AW-1:0] lf_req_addr = '0, ev_req_addr = '0, ld_req_addr = '0, ram_addr;
  logic [DW-1:0] lf_req_wdata = '0, ram_wdata, ram_rdata, ev_rsp_data, ld_rsp_data;
  logic [IW-1:0] ev_req_id = '0, ld_req_id = '0, ev_rsp_id, ld_rsp_id;
  typedef struct {int due; bit ld; logic [IW-1:0] id; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  logic [DW-1:0] mem [1<<AW];
  bit mem_ok [1<<AW];
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] rd_q [RL];
  int n_vec = 0, n_err = 0;
  int owner = 0, wait_c = 0, lf_len = 0, lf_beat = 0, ev_len = 0, ev_beat = 0;
  int p_lf, p_ev, p_ld;
  logic [AW-3:0] lf_line = '0, ev_line = '0;
  always #5 clk = ~clk;
  l1d_dat_ram_arb #(
    .RAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_LAT(RL), .STARVE_THR(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lf_req_vld(lf_req_vld), .lf_req_rdy(lf_req_rdy), .lf_req_addr(lf_req_addr),
    .lf_req_wdata(lf_req_wdata), .lf_req_last(lf_req_last),
    .ev_req_vld(ev_req_vld), .ev_req_rdy(ev_req_rdy), .ev_req_addr(ev_req_addr),
    .ev_req_id(ev_req_id), .ev_req_last(ev_req_last),
    .ld_req_vld(ld_req_vld), .ld_req_rdy(ld_req_rdy), .ld_req_addr(ld_req_addr), .ld_req_id(ld_req_id),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ev_rsp_vld(ev_rsp_vld), .ev_rsp_id(ev_rsp_id), .ev_rsp_data(ev_rsp_data),
    .ld_rsp_vld(ld_rsp_vld), .ld_rsp_id(ld_rsp_id), .ld_rsp_data(ld_rsp_data)
  );
  function automatic logic [DW-1:0] pat(input int a);
    return {16{8'hA5}} ^ DW'(a);
  endfunction
  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // SRAM model: unwritten words read back the preload pattern
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      mem_ok[ram_addr] <= 1'b1;
    end
    rd_q[0] <= mem_ok[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
    for (int i = 1; i < RL; i++) rd_q[i] <= rd_q[i-1];
  end
  assign ram_rdata = rd_q[RL-1];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(i);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst_n = cyc >= 3 && $urandom_range(0, 249) != 0;
      {p_lf, p_ev, p_ld} = cyc < 1000 ? {32'd40, 32'd40, 32'd50} :
                           cyc < 2000 ? {32'd100, 32'd0, 32'd100} : {32'd10, 32'd60, 32'd60};
      if (lf_len == 0) begin
        lf_len = $urandom_range(1, 4);
        lf_line = AW'($urandom) >> 2;
      end
      if (ev_len == 0) begin
        ev_len = cyc >= 2000 ? 1 : $urandom_range(1, 4);
        ev_line = AW'($urandom) >> 2;
        ev_req_id = cyc >= 2000 ? 4'd1 : IW'($urandom);
      end
      lf_req_vld = $urandom_range(0, 99) < p_lf;
      lf_req_addr = {lf_line, 2'(lf_beat)};
      lf_req_last = lf_beat == lf_len - 1;
      lf_req_wdata = rnd_data();
      ev_req_vld = $urandom_range(0, 99) < p_ev;
      ev_req_addr = {ev_line, 2'(ev_beat)};
      ev_req_last = ev_beat == ev_len - 1;
      ld_req_vld = $urandom_range(0, 99) < p_ld;
      ld_req_addr = cyc == 3 ? 9'h012 : AW'($urandom);
      ld_req_id = cyc >= 2000 ? 4'd5 : IW'($urandom);
      @(negedge clk);
      if (!rst_n) begin
        chk("rst lf_rdy", lf_req_rdy, 0);
        chk("rst ev_rdy", ev_req_rdy, 0);
        chk("rst ld_rdy", ld_req_rdy, 0);
        chk("rst ram_en", ram_en, 0);
        chk("rst ev_rsp_vld", ev_rsp_vld, 0);
        chk("rst ld_rsp_vld", ld_rsp_vld, 0);
        q.delete();
        {owner, wait_c, lf_len, lf_beat, ev_len, ev_beat} = '0;
      end else begin
        automatic bit top = wait_c >= THR && ld_req_vld;
        automatic bit e_lf = owner == 1 ? lf_req_vld : owner == 0 && !top && lf_req_vld;
        automatic bit e_ev = owner == 2 ? ev_req_vld : owner == 0 && !top && !lf_req_vld && ev_req_vld;
        automatic bit e_ld = owner == 0 && ld_req_vld && (top || (!lf_req_vld && !ev_req_vld));
        automatic exp_t e = '{due: -1, ld: 0, id: '0, data: '0};
        chk("lf_rdy", lf_req_rdy, e_lf);
        chk("ev_rdy", ev_req_rdy, e_ev);
        chk("ld_rdy", ld_req_rdy, e_ld);
        chk("ram_en", ram_en, e_lf || e_ev || e_ld);
        if (e_lf || e_ev || e_ld) begin
          chk("ram_we", ram_we, e_lf);
          chk("ram_addr", ram_addr, e_lf ? lf_req_addr : e_ev ? ev_req_addr : ld_req_addr);
        end
        if (e_lf) chk("ram_wdata", ram_wdata, lf_req_wdata);
        if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
        chk("ev_rsp_vld", ev_rsp_vld, e.due == cyc && !e.ld);
        chk("ld_rsp_vld", ld_rsp_vld, e.due == cyc && e.ld);
        if (e.due == cyc) begin
          chk("rsp_id", e.ld ? ld_rsp_id : ev_rsp_id, e.id);
          chk("rsp_data", e.ld ? ld_rsp_data : ev_rsp_data, e.data);
        end
        if (e_lf) begin
          shadow[lf_req_addr] = lf_req_wdata;
          owner = lf_req_last ? 0 : 1;
          lf_beat = lf_req_last ? 0 : lf_beat + 1;
          if (lf_req_last) lf_len = 0;
        end
        if (e_ev) begin
          q.push_back('{due: cyc + RL, ld: 0, id: ev_req_id, data: shadow[ev_req_addr]});
          owner = ev_req_last ? 0 : 2;
          ev_beat = ev_req_last ? 0 : ev_beat + 1;
          if (ev_req_last) ev_len = 0;
        end
        if (e_ld) q.push_back('{due: cyc + RL, ld: 1, id: ld_req_id, data: shadow[ld_req_addr]});
        wait_c = (e_ld || !ld_req_vld) ? 0 : wait_c < THR ? wait_c + 1 : wait_c;
      end
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
